// File: rtl/sub_serial_pkg.sv
// rtl/sub_serial_pkg.sv - shared types, defaults and reference model for the serial subtractor
package sub_serial_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_e;

    localparam int DEF_WIDTH = 4;

    // Reference result: borrow-out on top, modular difference below
    function automatic logic [DEF_WIDTH:0] ref_sub(input logic [DEF_WIDTH-1:0] a,
                                                   input logic [DEF_WIDTH-1:0] b);
        logic [DEF_WIDTH-1:0] diff;
        diff = a - b;
        return {(a < b), diff};
    endfunction

endpackage

// File: rtl/sub_serial_if.sv
// rtl/sub_serial_if.sv - operand/result handshake bundle for the serial subtractor
interface sub_serial_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   y;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/sub_serial_full_sub.sv
// rtl/sub_serial_full_sub.sv - combinational one-bit full subtractor cell
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    // Difference bit and borrow-out of x - y - bin
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end
endmodule

// File: rtl/sub_serial.sv
// rtl/sub_serial.sv - bit-serial unsigned subtractor, LSB first, one bit per clock
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic        aclk,
    input  logic        arst,
    sub_serial_if.slave bus,
    output logic        busy
);

    sub_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;
    logic [WIDTH:0]   y_q, y_d;
    logic             bit_d, bit_bout;
    logic             last_bit;

    full_sub u_cell (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (brw_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));
    assign bus.y    = y_q;

    // State register
    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept in IDLE, WIDTH shift cycles, hold DONE until taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decode directly from state
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        busy          = (state_q == SHIFT);
    end

    // Datapath next-state: load operands, then shift one bit per cycle
    always_comb begin
        cnt_d  = cnt_q;
        sa_d   = sa_q;
        sb_d   = sb_q;
        diff_d = diff_q;
        brw_d  = brw_q;
        y_d    = y_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sa_d   = bus.a;
                    sb_d   = bus.b;
                    brw_d  = 1'b0;
                    cnt_d  = '0;
                    diff_d = '0;
                end
            end
            SHIFT: begin
                sa_d   = sa_q >> 1;
                sb_d   = sb_q >> 1;
                brw_d  = bit_bout;
                diff_d = {bit_d, diff_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    y_d   = {bit_bout, bit_d, diff_q[WIDTH-1:1]};
                    cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            cnt_q  <= '0;
            sa_q   <= '0;
            sb_q   <= '0;
            diff_q <= '0;
            brw_q  <= 1'b0;
            y_q    <= '0;
        end else begin
            cnt_q  <= cnt_d;
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            diff_q <= diff_d;
            brw_q  <= brw_d;
            y_q    <= y_d;
        end
    end

endmodule

// File: tb/tb_sub_serial.sv
// tb/tb_sub_serial.sv - scoreboard bench for the serial subtractor
module tb_sub_serial;
    import sub_serial_pkg::*;

    localparam int W = DEF_WIDTH;

    logic aclk = 1'b0;
    logic arst = 1'b0;
    logic busy;

    sub_serial_if #(.WIDTH(W)) bus ();

    sub_serial #(.WIDTH(W)) dut (
        .aclk (aclk),
        .arst (arst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 aclk = ~aclk;

    int         checks   = 0;
    int         failures = 0;
    int         taken    = 0;
    logic [W:0] exp_q[$];
    logic [W:0] last_y   = '0;
    logic       prev_stall = 1'b0;
    logic [W:0] prev_y   = '0;
    bit         rand_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops scoreboard on each handshake, checks backpressure hold
    always @(negedge aclk) begin
        if (!arst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
                check("hold_y", 32'(bus.y), 32'(prev_y));
            end
            if (bus.out_valid && bus.out_ready) begin
                taken++;
                last_y = bus.y;
                if (exp_q.size() == 0) check("extra_result", 32'd1, 32'd0);
                else check("result_y", 32'(bus.y), 32'(exp_q.pop_front()));
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_y     = bus.y;
        end
    end

    // Drive one operand pair; entered and left one unit after a rising edge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        while (!ok) begin
            @(negedge aclk);
            ok = bus.in_ready && arst;
            if (!ok) begin
                n++;
                if (n > 200) begin
                    check("accept_timeout", 32'd0, 32'd1);
                    break;
                end
                @(posedge aclk); #1;
            end
        end
        if (ok) exp_q.push_back(ref_sub(a, b));
        @(posedge aclk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge aclk); #1;
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge aclk); #1;
    endtask

    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W:0] exp_y, input string tag);
        send(a, b);
        wait_drain();
        check(tag, 32'(last_y), 32'(exp_y));
    endtask

    task automatic run_busy(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int cnt = 0;
        int n = 0;
        send(a, b);
        while (n < 50) begin
            @(negedge aclk);
            if (bus.out_valid) break;
            if (busy) cnt++;
            n++;
            @(posedge aclk); #1;
        end
        check({tag, "_busy_cycles"}, 32'(cnt), 32'd4);
        wait_drain();
        check({tag, "_y"}, 32'(last_y), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge aclk);
        #1;
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_y", 32'(bus.y), 32'd0);
        arst = 1'b1;
        @(posedge aclk); #1;

        // Latency and in_ready profile for 9 - 3
        send(4'd9, 4'd3);
        for (int c = 1; c <= 5; c++) begin
            @(negedge aclk);
            check($sformatf("lat_in_ready_c%0d", c), {31'b0, bus.in_ready}, 32'd0);
            check($sformatf("lat_busy_c%0d", c), {31'b0, busy}, {31'b0, (c <= 4)});
            check($sformatf("lat_out_valid_c%0d", c), {31'b0, bus.out_valid}, {31'b0, (c == 5)});
            @(posedge aclk); #1;
        end
        @(negedge aclk);
        check("lat_c6_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("lat_c6_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("y_9_3", 32'(last_y), 32'b00110);
        @(posedge aclk); #1;

        run_one(4'd3, 4'd9, 5'b11010, "y_3_9");
        run_one(4'd0, 4'd15, 5'b10001, "y_0_15");
        run_busy(4'd15, 4'd15, "eq_15");
        run_busy(4'd0, 4'd0, "eq_0");

        // Backpressure: result held for 10 cycles, input pulses ignored
        bus.out_ready = 1'b0;
        send(4'd7, 4'd2);
        n = 0;
        while (n < 50) begin
            @(negedge aclk);
            if (bus.out_valid) break;
            n++;
            @(posedge aclk); #1;
        end
        check("hold_reached_done", {31'b0, bus.out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge aclk);
            check("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
            check("hold_y_7_2", 32'(bus.y), 32'b00101);
            check("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
            @(posedge aclk); #1;
            bus.in_valid = (i % 2 == 0);
            bus.a = 4'd14;
            bus.b = 4'd3;
        end
        base = taken;
        bus.out_ready = 1'b1;
        send(4'd1, 4'd1);
        check("hold_one_handshake", 32'(taken - base), 32'd1);
        wait_drain();
        check("hold_then_next", 32'(taken - base), 32'd2);
        check("y_1_1", 32'(last_y), 32'd0);

        // Reset during the second SHIFT cycle
        send(4'd12, 4'd5);
        @(posedge aclk); #1;
        arst = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("mid_rst_y", 32'(bus.y), 32'd0);
        check("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        exp_q.delete();
        base = taken;
        repeat (2) @(posedge aclk);
        #1;
        arst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            check("post_rst_no_valid", {31'b0, bus.out_valid}, 32'd0);
            @(posedge aclk); #1;
        end
        check("post_rst_no_result", 32'(taken - base), 32'd0);
        run_one(4'd12, 4'd5, 5'b00111, "y_12_5");

        // Random back-to-back stream with output stalls
        base = taken;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    logic [W-1:0] ra, rb;
                    ra = W'($urandom_range(0, 15));
                    rb = W'($urandom_range(0, 15));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge aclk); #1;
                    end
                    send(ra, rb);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge aclk); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_drain();
        check("rand_result_count", 32'(taken - base), 32'd200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sub_serial.md
Name: sub_serial

Overview:
- Bit-serial unsigned subtractor; the subtract-direction counterpart of the team's parallel adder in the adder/subtractor example.
- Accepts an operand pair over a valid/ready handshake.
- Computes a - b one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow.
- Presents a WIDTH+1-bit result (borrow-out plus difference) on an output valid/ready handshake.
- Sits beside the adder under the virtual sequencer, so sequences can drive add and subtract traffic concurrently.

Parameters:
- WIDTH, 4, operand width in bits; result is WIDTH+1 bits.
- CNT_W, $clog2(WIDTH), width of the bit-position counter; derived, do not override.

Ports:
- aclk  input  1  clock; all state updates on rising edge.
- arst  input  1  asynchronous, active-low reset. Low clears all state immediately; release is synchronous to aclk.
- in_valid  input  1  operand pair a, b valid this cycle.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  y holds a completed result.
- out_ready  input  1  downstream accepts y this cycle.
- y  output  WIDTH+1  y[WIDTH] = final borrow (1 when a < b); y[WIDTH-1:0] = (a - b) mod 2^WIDTH.
- busy  output  1  high while in SHIFT.

Behaviour:
- Reset (arst low): state=IDLE, in_ready=1, out_valid=0, busy=0, y=0, bit counter=0, borrow register=0, operand shift registers=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a into sa and b into sb, clear borrow, counter=0, clear the difference shift register, go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1.
  - Each cycle: d = sa[0]^sb[0]^brw; brw_next = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&brw).
  - Shift sa and sb right by 1; shift d into the MSB of the difference register.
  - Counter increments; when counter==WIDTH-1, go to DONE and load y={brw_next, diff_next}.
  - Takes exactly WIDTH cycles.
- DONE:
  - out_valid=1; y stable until handshake completes.
  - On out_ready: out_valid drops next cycle, go to IDLE.
- Latency: the accept edge is cycle 0; out_valid is high in cycle WIDTH+1.
- in_ready is low in SHIFT and DONE. No new operand is accepted until the result is taken (one transaction in flight).
- Back-to-back throughput: one result per WIDTH+2 cycles when out_ready is held high.
- out_valid must not drop, and y must not change, while out_ready is low (backpressure hold, indefinitely).
- in_valid asserted while in_ready=0: ignored; a and b are not sampled.
- Simultaneous out_ready in DONE and in_valid: the result is taken; the new operands are NOT accepted that cycle because in_ready=0. They are accepted in the following IDLE cycle.
- Reset mid-SHIFT or mid-DONE: the transaction is discarded, outputs go immediately to reset values, and no stale out_valid appears after release.
- Boundaries:
  - a==b gives y=0.
  - a=0, b=2^WIDTH-1 gives y={1, 1}.
  - Difference wraps modulo 2^WIDTH; the borrow bit carries the sign.
- y is registered; no combinational path from inputs to outputs except in_ready/out_valid derived from state.

Decomposition:
- Package sub_serial_pkg contains:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_e;
  - localparam int DEF_WIDTH = 4;
  - function ref_sub(a, b), returning {a<b, a-b}, shared with the scoreboard.
- One sub-module is natural: full_sub, a combinational 1-bit full subtractor with inputs x, y, bin and outputs d, bout. It is instantiated once in the datapath.

Test Plan:
- a=9, b=3, in_valid for 1 cycle, out_ready=1 -> out_valid in cycle 5; y=5'b0_0110; in_ready low cycles 1-5.
- a=3, b=9 -> y=5'b1_1010 (borrow=1, diff=10). Also a=0, b=15 -> y=5'b1_0001.
- a=15, b=15 and a=0, b=0 -> y=5'b0_0000; busy high exactly 4 cycles.
- Hold out_ready=0 for 10 cycles in DONE with a=7, b=2 -> y stays 5'b0_0101, out_valid stays 1, in_valid pulses ignored. Release gives one handshake, then IDLE.
- Assert arst low in the second SHIFT cycle of a=12, b=5 -> immediately out_valid=0, y=0, in_ready=1. After release, a=12, b=5 -> y=5'b0_0111.
- Random back-to-back stream of 200 pairs with random out_ready stalls -> every y matches ref_sub; no result lost or duplicated.
